// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
// Lets NUM_REQ independent requesters share one APB master controller.
//  - Pending requests are arbitrated round-robin, and the winner's command is latched.
//  - The latched command drives the controller's Transfer/RW/APB_Address/APB_Wr_Data/Strobe.
//  - Completion (PENABLE & PREADY_sel) returns read data and error to the winner,
//    together with a one-cycle req_done pulse.
// Optional feature macro: APB_ARB_TIMEOUT_EN
//  - When defined, a BUSY-cycle counter aborts a transfer after TIMEOUT_CYCLES
//    and reports rsp_err = 1.
//  - When undefined, BUSY waits indefinitely for PREADY_sel.
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    // requester side
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    input  logic [4*NUM_REQ-1:0]   req_strb,
    output logic [NUM_REQ-1:0]     req_grant,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    // controller side
    output logic                   Transfer,
    output logic                   RW,
    output logic [31:0]            APB_Address,
    output logic [31:0]            APB_Wr_Data,
    output logic [3:0]             Strobe,
    input  logic                   PENABLE,
    input  logic                   PREADY_sel,
    input  logic [31:0]            APB_Rd_Data,
    input  logic                   APB_Error
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_winner;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_rw;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_strb;

    logic               w_any;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_idx;
    logic               w_complete;
    logic               w_timeout;
    logic               w_finish;
    logic [IDX_W-1:0]   w_next_ptr;

    // Round-robin search: first valid index at or after r_rr_ptr, wrapping.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_complete = (r_state == ST_BUSY) && PENABLE && PREADY_sel;
    assign w_finish   = w_complete || w_timeout;
    assign w_next_ptr = (r_winner == IDX_W'(NUM_REQ-1)) ? '0 : r_winner + 1'b1;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts BUSY cycles; held at zero outside BUSY so it restarts on every grant.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ST_BUSY) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // The abort fires in the TIMEOUT_CYCLES-th BUSY cycle; a real completion
    // in that same cycle takes precedence.
    assign w_timeout = (r_state == ST_BUSY) && !w_complete &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Transfer drops combinationally in the completion (or abort) cycle so the
    // controller returns to its IDLE rather than starting a back-to-back transfer.
    assign Transfer = (r_state == ST_BUSY) && !(PENABLE && PREADY_sel) && !w_timeout;

    // Arbiter FSM: grant and latch in IDLE, wait in BUSY, pulse done in RESP.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_winner    <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= '0;
                    if (w_any) begin
                        r_winner <= w_winner;
                        r_grant  <= NUM_REQ'(1) << w_winner;
                        r_rw     <= req_rw[w_winner];
                        r_addr   <= req_addr[{w_winner, 5'b0} +: 32];
                        r_wdata  <= req_wdata[{w_winner, 5'b0} +: 32];
                        r_strb   <= req_strb[{w_winner, 2'b0} +: 4];
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_finish) begin
                        r_rsp_rdata <= (w_timeout || r_rw) ? 32'd0 : APB_Rd_Data;
                        r_rsp_err   <= w_timeout ? 1'b1 : APB_Error;
                        r_done      <= r_grant;
                        r_grant     <= '0;
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_done  <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_grant   = r_grant;
    assign req_done    = r_done;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign RW          = r_rw;
    assign APB_Address = r_addr;
    assign APB_Wr_Data = r_wdata;
    assign Strobe      = r_strb;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
// Directed bench for apb_req_arbiter.
//  - A small APB controller/slave model sits behind the arbiter:
//    IDLE -> SETUP -> ACCESS, with a programmable number of wait states.
//  - The APB_ARB_TIMEOUT_EN scenario is compiled in only when that macro is defined.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int N      = 4;
    localparam int TB_TMO = 8;

    logic             PCLK = 1'b0;
    logic             PRESETn;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_rw;
    logic [32*N-1:0]  req_addr;
    logic [32*N-1:0]  req_wdata;
    logic [4*N-1:0]   req_strb;
    logic [N-1:0]     req_grant;
    logic [N-1:0]     req_done;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             Transfer;
    logic             RW;
    logic [31:0]      APB_Address;
    logic [31:0]      APB_Wr_Data;
    logic [3:0]       Strobe;
    logic             PENABLE;
    logic             PREADY_sel;
    logic [31:0]      APB_Rd_Data;
    logic             APB_Error;

    int               n_chk = 0;
    int               n_err = 0;

    // slave model configuration
    int               slv_waits = 0;
    logic [31:0]      slv_rdata = 32'd0;
    logic             slv_err   = 1'b0;
    logic             slv_never = 1'b0;

    apb_req_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TB_TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .req_valid   (req_valid),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .req_grant   (req_grant),
        .req_done    (req_done),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .Transfer    (Transfer),
        .RW          (RW),
        .APB_Address (APB_Address),
        .APB_Wr_Data (APB_Wr_Data),
        .Strobe      (Strobe),
        .PENABLE     (PENABLE),
        .PREADY_sel  (PREADY_sel),
        .APB_Rd_Data (APB_Rd_Data),
        .APB_Error   (APB_Error)
    );

    always #5 PCLK = ~PCLK;

    // ---------------- controller + slave model ----------------
    typedef enum logic [1:0] {C_IDLE, C_SETUP, C_ACCESS} cst_t;
    cst_t c_st;
    int   c_wcnt;

    assign PENABLE     = (c_st == C_ACCESS);
    assign PREADY_sel  = (c_st == C_ACCESS) && !slv_never && (c_wcnt >= slv_waits);
    assign APB_Rd_Data = slv_rdata;
    assign APB_Error   = (c_st == C_ACCESS) && slv_err;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            c_st   <= C_IDLE;
            c_wcnt <= 0;
        end else begin
            case (c_st)
                C_IDLE:   if (Transfer) c_st <= C_SETUP;
                C_SETUP:  begin c_st <= C_ACCESS; c_wcnt <= 0; end
                C_ACCESS: begin
                    if (PREADY_sel) begin
                        c_st   <= Transfer ? C_SETUP : C_IDLE;
                        c_wcnt <= 0;
                    end else begin
                        c_wcnt <= c_wcnt + 1;
                    end
                end
                default:  c_st <= C_IDLE;
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for any req_done pulse; returns the observed vector.
    task automatic wait_done(input string tag, output logic [N-1:0] d);
        bit seen;
        seen = 1'b0;
        d    = '0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge PCLK);
            if (req_done != '0) begin
                seen = 1'b1;
                d    = req_done;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    // One request on requester idx.
    //  - Latency counts the cycles req_valid is high, up to and including the done cycle.
    //  - With chk_cmd set, the controller-facing command is checked on every granted cycle.
    task automatic run_req(input int idx, input logic rw, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int waits, input logic [31:0] rdata, input logic err,
                           input bit chk_cmd, output int lat, output logic [N-1:0] d);
        bit seen;
        slv_waits = waits;
        slv_rdata = rdata;
        slv_err   = err;
        @(negedge PCLK);
        req_rw[idx]            = rw;
        req_addr[32*idx +: 32] = addr;
        req_wdata[32*idx +: 32]= wdata;
        req_strb[4*idx +: 4]   = strb;
        req_valid[idx]         = 1'b1;
        lat  = 1;
        seen = 1'b0;
        d    = '0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge PCLK);
            lat++;
            if (req_done != '0) begin
                seen = 1'b1;
                d    = req_done;
            end else if (chk_cmd && req_grant != '0) begin
                check("cmd_rw",    32'(RW),          32'(rw));
                check("cmd_addr",  APB_Address,      addr);
                check("cmd_wdata", APB_Wr_Data,      wdata);
                check("cmd_strb",  32'(Strobe),      32'(strb));
            end
        end
        check("req_done_seen", 32'(seen), 32'd1);
        req_valid[idx] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(req_grant), 32'd0);
        check({tag, "_done"},  32'(req_done),  32'd0);
        check({tag, "_rdata"}, rsp_rdata,      32'd0);
        check({tag, "_err"},   32'(rsp_err),   32'd0);
        check({tag, "_xfer"},  32'(Transfer),  32'd0);
        check({tag, "_rw"},    32'(RW),        32'd0);
        check({tag, "_addr"},  APB_Address,    32'd0);
        check({tag, "_wdata"}, APB_Wr_Data,    32'd0);
        check({tag, "_strb"},  32'(Strobe),    32'd0);
    endtask

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          lat;
        logic [N-1:0] d;
        int          order [5];
        order = '{0, 1, 2, 3, 0};

        PRESETn   = 1'b0;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;

        // reset state
        repeat (3) @(negedge PCLK);
        check_all_zero("reset");
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        // single read, zero waits
        run_req(0, 1'b0, 32'h0001_0004, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1, lat, d);
        check("rd_latency", 32'(lat), 32'd5);
        check("rd_done",    32'(d),   32'b0001);
        check("rd_rdata",   rsp_rdata, 32'hDEAD_BEEF);
        check("rd_err",     32'(rsp_err), 32'd0);
        check("rd_xfer_in_resp", 32'(Transfer), 32'd0);
        @(negedge PCLK);
        check("rd_done_pulse", 32'(req_done), 32'd0);
        repeat (2) @(negedge PCLK);
        check("rd_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

        // write with three wait states; slave drives non-zero read data that must be ignored
        run_req(2, 1'b1, 32'h0002_0010, 32'h1234_5678, 4'b0011, 3, 32'hCAFE_F00D, 1'b0, 1'b1, lat, d);
        check("wr_latency", 32'(lat), 32'd8);
        check("wr_done",    32'(d),   32'b0100);
        check("wr_rdata",   rsp_rdata, 32'd0);
        check("wr_err",     32'(rsp_err), 32'd0);

        // slave error on a read (requester 3, which also brings the pointer back to 0)
        run_req(3, 1'b0, 32'h0003_0000, 32'h0, 4'h0, 1, 32'h55AA_55AA, 1'b1, 1'b0, lat, d);
        check("err_done",  32'(d),   32'b1000);
        check("err_err",   32'(rsp_err), 32'd1);
        check("err_rdata", rsp_rdata, 32'h55AA_55AA);
        check("err_latency", 32'(lat), 32'd6);

        // all four requesters continuously valid: fair rotation with wrap
        @(negedge PCLK);
        slv_waits = 0;
        slv_err   = 1'b0;
        slv_rdata = 32'hA5A5_0001;
        for (int i = 0; i < N; i++) begin
            req_rw[i]            = 1'b0;
            req_addr[32*i +: 32] = 32'h0004_0000 + 32'(i * 4);
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_done("rr", d);
            check($sformatf("rr_order%0d", k), 32'(d), 32'(1 << order[k]));
            check($sformatf("rr_xfer%0d", k), 32'(Transfer), 32'd0);
            if (k == 0) check("rr_err_cleared", 32'(rsp_err), 32'd0);
            if (k == 4) req_valid = '0;
        end
        check("rr_rdata", rsp_rdata, 32'hA5A5_0001);
        repeat (2) @(negedge PCLK);

        // async reset while requester 2 is in BUSY (pointer is 1 at this point)
        slv_waits = 10;
        slv_rdata = 32'h7777_7777;
        req_addr[64 +: 32] = 32'h0005_0000;
        req_rw[2]          = 1'b1;
        req_wdata[64 +: 32]= 32'hFFFF_FFFF;
        req_strb[8 +: 4]   = 4'hF;
        req_valid[2]       = 1'b1;
        repeat (4) @(negedge PCLK);
        check("rst_pre_grant", 32'(req_grant), 32'b0100);
        #2 PRESETn = 1'b0;
        #1 check_all_zero("rst_mid");
        req_valid = '0;
        @(negedge PCLK);
        PRESETn   = 1'b1;
        slv_waits = 0;
        slv_rdata = 32'h0000_1234;
        req_rw[0] = 1'b0;
        req_rw[3] = 1'b0;
        req_valid = 4'b1001;
        @(negedge PCLK);
        check("rst_after_grant", 32'(req_grant), 32'b0001);
        check("rst_after_done",  32'(req_done),  32'd0);
        wait_done("rst_a", d);
        check("rst_a_done", 32'(d), 32'b0001);
        req_valid[0] = 1'b0;
        wait_done("rst_b", d);
        check("rst_b_done", 32'(d), 32'b1000);
        req_valid[3] = 1'b0;
        repeat (2) @(negedge PCLK);

        // requester 1 drops valid mid-BUSY while requester 3 arrives: no preemption
        slv_waits = 2;
        slv_rdata = 32'h0BAD_F00D;
        req_rw[1] = 1'b0;
        req_valid[1] = 1'b1;
        repeat (2) @(negedge PCLK);
        check("drop_grant", 32'(req_grant), 32'b0010);
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1;
        @(negedge PCLK);
        check("nopreempt_grant", 32'(req_grant), 32'b0010);
        wait_done("drop", d);
        check("drop_done",  32'(d), 32'b0010);
        check("drop_rdata", rsp_rdata, 32'h0BAD_F00D);
        slv_rdata = 32'h3333_0003;
        wait_done("late", d);
        check("late_done",  32'(d), 32'b1000);
        check("late_rdata", rsp_rdata, 32'h3333_0003);
        req_valid[3] = 1'b0;
        repeat (2) @(negedge PCLK);

`ifdef APB_ARB_TIMEOUT_EN
        // slave never ready: abort after TB_TMO BUSY cycles
        slv_never = 1'b1;
        run_req(0, 1'b0, 32'h0006_0000, 32'h0, 4'h0, 0, 32'h9999_9999, 1'b0, 1'b0, lat, d);
        check("tmo_latency", 32'(lat), 32'(TB_TMO + 2));
        check("tmo_done",    32'(d), 32'b0001);
        check("tmo_err",     32'(rsp_err), 32'd1);
        check("tmo_rdata",   rsp_rdata, 32'd0);
        @(negedge PCLK);
        check("tmo_idle_grant", 32'(req_grant), 32'd0);
        check("tmo_idle_xfer",  32'(Transfer),  32'd0);
        check("tmo_idle_done",  32'(req_done),  32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
